// File: rtl/vector_store_unit.sv
// Vector store unit: serialises lanes 0..7 of a 16x16-bit vector register into
// a byte-wide image memory, one masked byte write per unstalled cycle.
module vector_store_unit #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int PIX_SIZE     = 8,
  parameter int SAT          = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [15:0]         Addr,
  input  logic [15:0][15:0]   WD,
  input  logic [7:0]          mask,
  input  logic                mem_stall,
  output logic                mem_we,
  output logic [15:0]         mem_addr,
  output logic [PIX_SIZE-1:0] mem_wd,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0] DEPTH = 16'(IMAGE_WIDTH * IMAGE_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          lane_q, lane_d;
  logic [15:0]         base_q, base_d;
  logic [7:0][15:0]    data_q, data_d;
  logic [7:0]          mask_q, mask_d;
  logic                mem_we_q, mem_we_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [PIX_SIZE-1:0] mem_wd_q, mem_wd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [15:0]         lane_sum;
  logic [15:0]         lane_addr;
  logic [15:0]         lane_val;
  logic [PIX_SIZE-1:0] lane_byte;
  logic                unused_upper_lanes;

  // Lanes 8..15 never reach memory from this unit.
  assign unused_upper_lanes = ^WD[15:8];

  // base_q is already reduced below DEPTH, so one conditional subtract wraps.
  assign lane_sum  = base_q + {12'd0, lane_q};
  assign lane_addr = (lane_sum >= DEPTH) ? (lane_sum - DEPTH) : lane_sum;
  assign lane_val  = data_q[lane_q[2:0]];

  always_comb begin
    lane_byte = lane_val[PIX_SIZE-1:0];
    if ((SAT != 0) && ((lane_val >> PIX_SIZE) != 16'd0)) lane_byte = '1;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    lane_d     = lane_q;
    base_d     = base_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = Addr % DEPTH;
          data_d  = WD[7:0];
          mask_d  = mask;
          lane_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Lane index 8 is the bookkeeping slot that lines done up with S_DONE.
        if (lane_q == 4'd8) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (!mem_stall) begin
          mem_addr_d = lane_addr;
          mem_wd_d   = lane_byte;
          mem_we_d   = mask_q[lane_q[2:0]];
          lane_d     = lane_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      lane_q     <= 4'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 16'd0;
      mem_wd_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: payload registers are always loaded before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    base_q <= base_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Bench for vector_store_unit: a saturating and a truncating instance share
// stimulus; a scoreboard checks every write's cycle, address and byte.
module tb_vector_store_unit;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [15:0]      Addr;
  logic [15:0][15:0] WD;
  logic [7:0]       mask;
  logic             mem_stall;

  logic        we_s, we_t;
  logic [15:0] addr_s, addr_t;
  logic [7:0]  wd_s, wd_t;
  logic        busy_s, busy_t, done_s, done_t;

  always #5 CLK = ~CLK;

  vector_store_unit #(.SAT(1)) dut_s (
    .CLK(CLK), .RST(RST), .start(start), .Addr(Addr), .WD(WD), .mask(mask),
    .mem_stall(mem_stall), .mem_we(we_s), .mem_addr(addr_s), .mem_wd(wd_s),
    .busy(busy_s), .done(done_s)
  );

  vector_store_unit #(.SAT(0)) dut_t (
    .CLK(CLK), .RST(RST), .start(start), .Addr(Addr), .WD(WD), .mask(mask),
    .mem_stall(mem_stall), .mem_we(we_t), .mem_addr(addr_t), .mem_wd(wd_t),
    .busy(busy_t), .done(done_t)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  sat;
    logic [7:0]  trunc;
    int          rel;
  } sb_t;

  typedef struct {
    logic [15:0]      addr;
    logic [7:0][15:0] lanes;
    logic [7:0]       mask;
    logic [7:0][15:0] exp_addr;
    bit               poke;
  } vec_t;

  sb_t        sbq[$];
  logic [7:0] img [0:9215];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_rel = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sat_of(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // One clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    sb_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (we_s !== we_t) check("we_match", 32'(we_t), 32'(we_s));
    if (we_s === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_write_addr", 32'(addr_s), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("wr_cycle", 32'(cyc - acc_cyc), 32'(e.rel));
        check("wr_addr", 32'(addr_s), 32'(e.addr));
        check("wr_data_sat", 32'(wd_s), 32'(e.sat));
        check("wr_addr_trunc", 32'(addr_t), 32'(e.addr));
        check("wr_data_trunc", 32'(wd_t), 32'(e.trunc));
        if (addr_s < 16'd9216) img[addr_s] = wd_s;
      end
    end
    if (done_s === 1'b1) begin
      done_cnt++;
      done_rel = cyc - acc_cyc;
    end
  endtask

  task automatic run_store(input logic [15:0] a, input logic [7:0][15:0] lanes,
                           input logic [7:0] m, input logic [7:0][15:0] exp_addr,
                           input bit poke);
    logic [7:0] snap [8];
    for (int i = 0; i < 8; i++) begin
      snap[i] = img[exp_addr[i]];
      if (m[i]) sbq.push_back('{exp_addr[i], sat_of(lanes[i]), lanes[i][7:0], i + 1});
    end
    done_cnt = 0;
    done_rel = -1;
    Addr  = a;
    mask  = m;
    WD    = {{8{16'hDEAD}}, lanes};
    start = 1'b1;
    step();
    acc_cyc = cyc;
    start = 1'b0;
    Addr  = 16'hBEEF;
    mask  = ~m;
    WD    = '1;
    check("busy_after_accept", 32'(busy_s), 32'd1);
    for (int r = 1; r <= 9; r++) step();
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_rel), 32'd9);
    check("busy_at_done", 32'(busy_s), 32'd0);
    if (poke) begin
      start = 1'b1;
      Addr  = a;
    end
    step();
    start = 1'b0;
    check("done_pulse_width", 32'(done_s), 32'd0);
    check("busy_back_idle", 32'(busy_s), 32'd0);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    for (int i = 0; i < 8; i++) begin
      if (m[i]) check("img_written", 32'(img[exp_addr[i]]), 32'(sat_of(lanes[i])));
      else      check("img_untouched", 32'(img[exp_addr[i]]), 32'(snap[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];

    for (int i = 0; i < 9216; i++) img[i] = 8'(i * 7 + 3);

    tbl[0] = '{16'd100,
               {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 8'hFF,
               {16'd107, 16'd106, 16'd105, 16'd104, 16'd103, 16'd102, 16'd101, 16'd100}, 1'b0};
    tbl[1] = '{16'd200,
               {16'h0080, 16'h8000, 16'h0000, 16'h00FE, 16'h0100, 16'hFFFF, 16'h00FF, 16'h0123}, 8'hFF,
               {16'd207, 16'd206, 16'd205, 16'd204, 16'd203, 16'd202, 16'd201, 16'd200}, 1'b1};
    tbl[2] = '{16'd0,
               {16'h88, 16'h77, 16'h66, 16'h55, 16'h44, 16'h33, 16'h22, 16'h11}, 8'b1010_0101,
               {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1'b0};
    tbl[3] = '{16'd9214,
               {16'h48, 16'h47, 16'h46, 16'h45, 16'h44, 16'h43, 16'h42, 16'h41}, 8'hFF,
               {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd9215, 16'd9214}, 1'b0};
    tbl[4] = '{16'd9216,
               {16'h0C8, 16'h0C7, 16'h0C6, 16'h0C5, 16'h0C4, 16'h0C3, 16'h0C2, 16'h0C1}, 8'hFF,
               {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1'b0};
    tbl[5] = '{16'd65535,
               {16'h1FF, 16'h0F7, 16'h0F6, 16'h0F5, 16'h0F4, 16'h0F3, 16'h0F2, 16'h0F1}, 8'hFF,
               {16'd1030, 16'd1029, 16'd1028, 16'd1027, 16'd1026, 16'd1025, 16'd1024, 16'd1023}, 1'b0};
    tbl[6] = '{16'd50,
               {16'h9, 16'h9, 16'h9, 16'h9, 16'h9, 16'h9, 16'h9, 16'h9}, 8'h00,
               {16'd57, 16'd56, 16'd55, 16'd54, 16'd53, 16'd52, 16'd51, 16'd50}, 1'b1};

    RST = 1'b1;
    start = 1'b0;
    Addr = 16'd0;
    WD = '0;
    mask = 8'h00;
    mem_stall = 1'b0;
    step();
    step();
    check("rst_we", 32'(we_s), 32'd0);
    check("rst_addr", 32'(addr_s), 32'd0);
    check("rst_wd", 32'(wd_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_busy_trunc", 32'(busy_t), 32'd0);
    RST = 1'b0;
    step();

    for (int k = 0; k < 7; k++)
      run_store(tbl[k].addr, tbl[k].lanes, tbl[k].mask, tbl[k].exp_addr, tbl[k].poke);

    // Stall on lane 2 across three edges, with a start pulse that must be ignored.
    for (int i = 0; i < 8; i++)
      sbq.push_back('{16'(300 + i), 8'(16 + i), 8'(16 + i), (i < 2) ? i + 1 : i + 4});
    done_cnt = 0;
    done_rel = -1;
    Addr = 16'd300;
    mask = 8'hFF;
    for (int i = 0; i < 8; i++) WD[i] = 16'(16 + i);
    start = 1'b1;
    step();
    acc_cyc = cyc;
    start = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      mem_stall = (r >= 3 && r <= 5);
      start = (r == 4);
      Addr = 16'd500;
      step();
      if (r >= 3 && r <= 5) begin
        check("stall_we", 32'(we_s), 32'd0);
        check("stall_addr_hold", 32'(addr_s), 32'd301);
        check("stall_data_hold", 32'(wd_s), 32'h11);
        check("stall_busy", 32'(busy_s), 32'd1);
      end
    end
    mem_stall = 1'b0;
    start = 1'b0;
    check("stall_done_count", 32'(done_cnt), 32'd1);
    check("stall_done_cycle", 32'(done_rel), 32'd12);
    step();
    check("stall_sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();

    // Reset during lane 3: lanes 0..2 already written, nothing afterwards.
    for (int i = 0; i < 3; i++)
      sbq.push_back('{16'(400 + i), 8'(32 + i), 8'(32 + i), i + 1});
    done_cnt = 0;
    Addr = 16'd400;
    mask = 8'hFF;
    for (int i = 0; i < 8; i++) WD[i] = 16'(32 + i);
    start = 1'b1;
    step();
    acc_cyc = cyc;
    start = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      RST = (r == 4);
      step();
    end
    check("abort_we", 32'(we_s), 32'd0);
    check("abort_busy", 32'(busy_s), 32'd0);
    check("abort_done", 32'(done_s), 32'd0);
    check("abort_addr", 32'(addr_s), 32'd0);
    RST = 1'b0;
    for (int r = 0; r < 6; r++) step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_sb_drained", 32'(sbq.size()), 32'd0);
    check("abort_idle_busy", 32'(busy_s), 32'd0);
    sbq.delete();

    run_store(16'd400,
              {16'h37, 16'h36, 16'h35, 16'h34, 16'h33, 16'h32, 16'h31, 16'h30}, 8'hFF,
              {16'd407, 16'd406, 16'd405, 16'd404, 16'd403, 16'd402, 16'd401, 16'd400}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_store_unit.md
Name: vector_store_unit

Overview:
- Write-side counterpart of the vector data memory read port.
- Takes one vector store request: a 16-lane x 16-bit vector register value, a base address and a lane mask.
- Serialises lanes 0..7 into the byte-wide image memory, one byte per cycle, through a single write port.
- Sits between the vector execute stage and the byte image memory; the CPU stalls on busy.

Parameters:
- IMAGE_WIDTH, 96, image width in pixels.
- IMAGE_HEIGHT, 96, image height in pixels.
- PIX_SIZE, 8, bits per stored pixel/byte.
- SAT, 1, 1 = saturate lane values >255 to 255; 0 = truncate to the low PIX_SIZE bits.
- DEPTH is derived, not a parameter: DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT = 9216.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  store request, sampled in IDLE only.
- Addr  input  16  base byte address of lane 0.
- WD  input  16x16  vector data, packed [15:0][15:0]; lanes 8..15 ignored.
- mask  input  8  per-lane write enable for lanes 0..7.
- mem_stall  input  1  memory not ready; hold the current lane.
- mem_we  output  1  byte write enable.
- mem_addr  output  16  byte write address, always < DEPTH.
- mem_wd  output  PIX_SIZE  byte write data.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the store completes.

Behaviour:
- Reset values (registered outputs, all zero):
  - mem_we=0, mem_addr=0, mem_wd=0, busy=0, done=0.
  - State = IDLE; lane counter = 0.
- Acceptance:
  - In IDLE, start=1 captures Addr, WD[7:0] (lanes 0..7) and mask into internal registers.
  - Next state is WRITE, lane=0, busy=1 from the next cycle.
  - Inputs may change after acceptance without effect.
- WRITE state:
  - Each cycle with mem_stall=0 presents lane i on registered outputs:
    - mem_addr = (base+i) mod DEPTH.
    - mem_wd = conv(WD[i]).
    - mem_we = mask[i].
  - Then i increments.
  - Masked-off lanes still consume one cycle, with mem_we=0 and address/data still driven, so latency is deterministic.
  - With mem_stall=1, outputs hold their values, mem_we is forced to 0 and the lane does not advance. The stalled lane is re-presented with mem_we=mask[i] once the stall clears.
- Completion:
  - After lane 7 is issued, the state moves to DONE.
  - DONE lasts one cycle: done=1, busy=0, mem_we=0. Then back to IDLE.
  - Unstalled latency: accept at cycle 0, writes on cycles 1..8, done on cycle 9.
- conv():
  - SAT=1: value > 255 gives 8'hFF, otherwise the low 8 bits.
  - SAT=0: WD[i][7:0].
  - Values are treated as unsigned.
- Address wrap:
  - base >= DEPTH is first reduced modulo DEPTH.
  - base+i >= DEPTH wraps to base+i-DEPTH. Example: base 9214, lanes 0..7 go to 9214, 9215, 0, 1, ..., 5.
  - mem_addr never reaches DEPTH.
- Simultaneous events:
  - start while busy or in DONE is ignored; there is no queue.
  - start in the DONE cycle is ignored; the caller re-asserts in IDLE.
  - RST has priority over everything.
- Reset mid-operation: on a clock edge with RST=1, the store aborts. Already-written bytes stay written, and mem_we is 0 from that edge.
- Read coherence: a vector read of the same 8 bytes issued after done returns the new bytes zero-extended in lanes 0..7.
- mask=8'h00: the full 8-cycle sequence with no writes, then done.

Test Plan:
- Basic store: reset, then start with Addr=100, WD lanes 0..7 = 1..8, mask=FF.
  - mem_we high cycles 1..8, addresses 100..107, data 01..08.
  - done on cycle 9; a read at 100 returns lanes 1..8 and lanes 8..15 = 0.
- Saturation:
  - SAT=1, lane0=16'h0123, lane1=16'h00FF, lane2=16'hFFFF → written bytes FF, FF, FF.
  - SAT=0, same lanes → written bytes 23, FF, FF.
- Mask: mask=8'b10100101 with Addr=0 → writes only at addresses 0, 2, 5, 7; 8 WRITE cycles; done on cycle 9; other bytes unchanged.
- Wrap: Addr=9214, mask=FF → addresses 9214, 9215, 0, 1, 2, 3, 4, 5.
  - Addr=9216 behaves as base 0.
- Stall and ignored start: mem_stall=1 on cycles 3-5 (lane 2 pending).
  - Lane 2 is written on cycle 6 and done moves to cycle 12.
  - A start pulse on cycle 4 has no effect.
- Reset abort: RST on cycle 4 → lanes 0..2 written, mem_we=0 from that edge, busy=0, no done.
  - A new start afterwards completes normally.
